// File: rtl/rnd_mem_tester.sv
// rnd_mem_tester: random-pattern memory test sequencer.
// Each pass saves the generator state, writes one random word to every
// address, restores the generator, then reads every address back and
// compares it against the regenerated stream.
// Optional feature macro: RND_TEST_ERRLOG_EN enables first-error capture
// (err_addr/err_exp/err_got). Without it those outputs are tied to 0.
module rnd_mem_tester #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int INIT_LEN  = 8,
  parameter int ERRCNT_W  = 16,
  parameter int PASSCNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 rnd_init,
  output logic                 rnd_save,
  output logic                 rnd_restore,
  output logic                 rnd_next,
  input  logic [DATA_W-1:0]    rnd_in,
  output logic                 mem_req,
  output logic                 mem_rnw,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic [PASSCNT_W-1:0] pass_cnt,
  output logic [ERRCNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [DATA_W-1:0]    err_exp,
  output logic [DATA_W-1:0]    err_got
);

  localparam logic [3:0] S_INIT = 4'd0;
  localparam logic [3:0] S_IDLE = 4'd1;
  localparam logic [3:0] S_SAVE = 4'd2;
  localparam logic [3:0] S_WR   = 4'd3;
  localparam logic [3:0] S_WNX  = 4'd4;
  localparam logic [3:0] S_RST  = 4'd5;
  localparam logic [3:0] S_RD   = 4'd6;
  localparam logic [3:0] S_RNX  = 4'd7;
  localparam logic [3:0] S_PASS = 4'd8;

  localparam int CNT_W = $clog2(INIT_LEN + 1);
  localparam logic [CNT_W-1:0] INIT_END = CNT_W'(INIT_LEN);

  logic [3:0]       state;
  logic [CNT_W-1:0] init_cnt;
  logic             last_addr;
  logic             rd_ack;
  logic             mismatch;

  assign last_addr = &mem_addr;
  assign rd_ack    = (state == S_RD) && mem_ack;
  assign mismatch  = (mem_rdata != rnd_in);

  // init_cnt == 0 only in the post-reset cycle, which keeps every output low
  assign rnd_init    = (state == S_INIT) && (init_cnt != '0);
  assign rnd_save    = (state == S_SAVE);
  assign rnd_restore = (state == S_RST);
  assign rnd_next    = (state == S_WNX) || (state == S_RNX);
  assign mem_req     = (state == S_WR) || (state == S_RD);
  assign mem_rnw     = (state == S_RD);
  assign mem_wdata   = (state == S_WR) ? rnd_in : '0;
  assign busy        = (state != S_IDLE) && !((state == S_INIT) && (init_cnt == '0));

  // sequencer FSM, address and pass counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
      mem_addr <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_END) state <= S_IDLE;
          else                      init_cnt <= init_cnt + CNT_W'(1);
        end
        S_IDLE: begin
          mem_addr <= '0;
          if (run) state <= S_SAVE;
        end
        S_SAVE: state <= S_WR;
        S_WR:   if (mem_ack) state <= S_WNX;
        S_WNX: begin
          if (last_addr) begin
            mem_addr <= '0;
            state    <= S_RST;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= S_WR;
          end
        end
        S_RST:  state <= S_RD;
        S_RD:   if (mem_ack) state <= S_RNX;
        S_RNX: begin
          if (last_addr) begin
            mem_addr <= '0;
            state    <= S_PASS;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            state    <= S_RD;
          end
        end
        S_PASS: begin
          pass_cnt <= pass_cnt + PASSCNT_W'(1);
          state    <= run ? S_SAVE : S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // saturating mismatch counter
  always_ff @(posedge clk) begin
    if (!rst_n)                              err_cnt <= '0;
    else if (rd_ack && mismatch && !(&err_cnt)) err_cnt <= err_cnt + ERRCNT_W'(1);
  end

`ifdef RND_TEST_ERRLOG_EN
  logic err_seen;

  // latch the first mismatch after reset, hold it thereafter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_seen <= 1'b0;
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (rd_ack && mismatch && !err_seen) begin
      err_seen <= 1'b1;
      err_addr <= mem_addr;
      err_exp  <= rnd_in;
      err_got  <= mem_rdata;
    end
  end
`else
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_got  = '0;
`endif

endmodule

// File: doc/rnd_mem_tester.md
# rnd_mem_tester

Memory test sequencer that consumes the pseudo-random vector stream of `rnd_vec_gen` and drives a simple request/acknowledge memory port. Each pass saves the generator state, writes one random word to every address, restores the generator, then reads every address back and compares it against the regenerated stream. It sits between `rnd_vec_gen`, which it controls through init/save/restore/next strobes, and the DRAM controller's test port, and publishes pass and error statistics.

## Interface
Parameters:
- `DATA_W`, 16: data width; must equal `rnd_vec_gen` `OUT_SIZE`.
- `ADDR_W`, 10: address width; each pass covers 0 .. 2^ADDR_W-1.
- `INIT_LEN`, 8: cycles `rnd_init` is held high after reset; minimum 2.
- `ERRCNT_W`, 16: error counter width.
- `PASSCNT_W`, 8: pass counter width.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: level; high starts and continues passes.
- `rnd_init`, `rnd_save`, `rnd_restore`, `rnd_next` out 1 each: strobes to `rnd_vec_gen`.
- `rnd_in` in DATA_W: `rnd_vec_gen` output.
- `mem_req` out 1: access request, held until acknowledged.
- `mem_rnw` out 1: 1 = read, 0 = write.
- `mem_addr` out ADDR_W: access address.
- `mem_wdata` out DATA_W: write data.
- `mem_ack` in 1: one-cycle completion pulse; read data is valid in the same cycle.
- `mem_rdata` in DATA_W: read data.
- `busy` out 1: high in every state except IDLE.
- `pass_cnt` out PASSCNT_W: completed passes, wrapping.
- `err_cnt` out ERRCNT_W: mismatched words, saturating at all-ones.
- `err_addr` out ADDR_W, `err_exp` out DATA_W, `err_got` out DATA_W: first-error capture.

## Operation
- States: INIT, IDLE, SAVE, WR, WNX, RST, RD, RNX, PASS.
- INIT: `rnd_init`=1 for exactly INIT_LEN cycles, then go to IDLE.
- IDLE: if `run` is high, go to SAVE; `mem_addr` is cleared to 0.
- SAVE: `rnd_save`=1 for 1 cycle, then go to WR.
- WR: `mem_req`=1, `mem_rnw`=0, `mem_wdata`=`rnd_in`. When `mem_ack`=1, go to WNX.
- WNX: `rnd_next`=1 for 1 cycle.
  - If `mem_addr` is all-ones, clear it to 0 and go to RST.
  - Otherwise increment `mem_addr` and go to WR.
- RST: `rnd_restore`=1 for 1 cycle, then go to RD.
- RD: `mem_req`=1, `mem_rnw`=1. On `mem_ack`, compare `mem_rdata` with `rnd_in`.
  - On mismatch, increment `err_cnt` (saturating).
  - If this is the first error since reset, latch `mem_addr`, `rnd_in` and `mem_rdata` into `err_addr`, `err_exp` and `err_got`.
  - Go to RNX.
- RNX: same as WNX, except the last address goes to PASS.
- PASS: increment `pass_cnt` (wrapping). If `run` is high go to SAVE, otherwise go to IDLE.
- Generator state after the read sweep equals its state after the write sweep. The next pass's SAVE therefore produces fresh data.
- `run` dropping mid-pass has no effect until PASS; a started pass always completes.
- Strobes are mutually exclusive, each exactly one cycle long, and are a decode of the current state.

## Timing
- Reset values: every output is 0, including counters and capture registers. The state is INIT and `rnd_init` is 0 in the first cycle after reset.
- Reset asserted mid-access drops `mem_req` in the next cycle. The memory side must tolerate an aborted request.
- `mem_ack` may arrive in any cycle `mem_req` is high, including the first; `mem_ack` while `mem_req` is low is ignored.
- `mem_req` is low in the cycle after ack (the WNX/RNX cycle), so consecutive accesses are separated by one idle cycle.
- `mem_addr`, `mem_rnw` and `mem_wdata` are stable for the whole time `mem_req` is high.
- Generator updates take effect one cycle after a strobe, so `rnd_in` is valid on entry to WR/RD. This applies after SAVE, WNX, RST and RNX.
- Minimum pass length with zero-wait ack: 2 + 4·2^ADDR_W cycles, plus 1 cycle for PASS.

## Configuration
- `RND_TEST_ERRLOG_EN` defined: first-error capture registers are implemented as described in Operation.
- Not defined: `err_addr`, `err_exp` and `err_got` are constant 0 and no capture flops are synthesised. `err_cnt` is unaffected either way.

## Test plan
- Reset, then `run`=0 for 20 cycles → `rnd_init` high for exactly 8 cycles, `busy`=0 afterwards, all counters 0.
- Bench uses ADDR_W=2, ideal RAM model with zero-wait ack, `run`=1 → 4 writes at addresses 0..3, then 4 reads. Result: `pass_cnt`=1, `err_cnt`=0; write data of pass 2 differs from pass 1.
- RAM model corrupts the read of address 2 by XOR 0x0001 → `err_cnt`=1, `err_addr`=2, `err_got`=`err_exp`^0x0001. Second pass with the same fault → `err_cnt`=2, capture registers unchanged.
- Ack delayed a random 0..5 cycles, including an ack on the first request cycle → `mem_addr`, `mem_rnw` and `mem_wdata` stable while `mem_req` is high, `err_cnt`=0 after 3 passes.
- `run` dropped during the write sweep → the pass completes, `pass_cnt` increments by 1, FSM returns to IDLE with `busy`=0. `rst_n`=0 mid-read → all outputs 0 the next cycle, INIT re-runs.
- Force `err_cnt` near the top (ERRCNT_W=2) with every read corrupted → `err_cnt` saturates at 3. Rebuild without `RND_TEST_ERRLOG_EN` → `err_addr`, `err_exp` and `err_got` read 0.
